// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types and constants
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;
    localparam logic [31:0] PC_INC = 32'd4;

    typedef enum logic [2:0] {
        FS_IDLE  = 3'd0,
        FS_REQ   = 3'd1,
        FS_WAIT  = 3'd2,
        FS_DONE  = 3'd3,
        FS_DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - multicycle instruction fetch sequencer driving the PC write port
module instr_fetch_unit #(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] PC,
    input  logic            fetch_start,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            flush,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_err,
    output logic [XLEN-1:0] NPC,
    output logic            PCwr,
    output logic [XLEN-1:0] IR,
    output logic            ir_valid,
    output logic            fetch_done,
    output logic            fault
);

    import riscv_pkg::*;

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_d;
    logic [XLEN-1:0] iaddr_d;
    logic [XLEN-1:0] npc_d;
    logic            pcwr_d;
    logic [XLEN-1:0] ir_d;
    logic            irv_d;
    logic            done_d;
    logic            fault_d;

    // State register; reset drops any in-flight transaction so a late response lands in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FS_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-output decode; every output is registered one cycle later
    always_comb begin
        state_d = state;
        addr_d  = addr_q;
        req_d   = 1'b0;
        iaddr_d = imem_addr;
        npc_d   = NPC;
        pcwr_d  = 1'b0;
        ir_d    = IR;
        irv_d   = ir_valid;
        done_d  = 1'b0;
        fault_d = 1'b0;
        case (state)
            FS_IDLE: begin
                if (redirect_valid) begin
                    // A redirect preempts a simultaneous fetch request; control re-issues the fetch
                    pcwr_d = 1'b1;
                    npc_d  = redirect_pc;
                end else if (fetch_start) begin
                    addr_d = PC;
                    irv_d  = 1'b0;
                    if (PC[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                    end else begin
                        state_d = FS_REQ;
                        req_d   = 1'b1;
                        iaddr_d = PC;
                    end
                end
            end
            FS_REQ: begin
                if (imem_gnt) begin
                    // Once granted the response is owed to us, so a flush must still drain it
                    state_d = flush ? FS_DRAIN : FS_WAIT;
                end else if (flush) begin
                    state_d = FS_IDLE;
                end else begin
                    req_d = 1'b1;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        state_d = FS_IDLE;
                    end else if (imem_err) begin
                        ir_d    = NOP_INSN;
                        fault_d = 1'b1;
                        state_d = FS_IDLE;
                    end else begin
                        ir_d    = imem_rdata;
                        irv_d   = 1'b1;
                        pcwr_d  = 1'b1;
                        npc_d   = addr_q + XLEN'(PC_INC);
                        done_d  = 1'b1;
                        state_d = FS_DONE;
                    end
                end else if (flush) begin
                    state_d = FS_DRAIN;
                end
            end
            FS_DONE: begin
                state_d = FS_IDLE;
            end
            FS_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = FS_IDLE;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q     <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            NPC        <= '0;
            PCwr       <= 1'b0;
            IR         <= NOP_INSN;
            ir_valid   <= 1'b0;
            fetch_done <= 1'b0;
            fault      <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            imem_req   <= req_d;
            imem_addr  <= iaddr_d;
            NPC        <= npc_d;
            PCwr       <= pcwr_d;
            IR         <= ir_d;
            ir_valid   <= irv_d;
            fetch_done <= done_d;
            fault      <= fault_d;
        end
    end

endmodule
